// File: rtl/midi_pkg.sv
// Shared MIDI definitions: receiver state encoding, bit-timing helpers and
// protocol constants used by the receiver and the controller.
package midi_pkg;

  localparam int unsigned MIDI_BAUD = 31_250;
  localparam logic [7:0] MIDI_STATUS_MASK = 8'h80;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_e;

  // Clock cycles per serial bit (integer division).
  function automatic int unsigned bit_cycles(input int unsigned clock_hz,
                                             input int unsigned baud);
    return clock_hz / baud;
  endfunction

  // Clock cycles from the start-bit edge to the middle of the start bit.
  function automatic int unsigned half_cycles(input int unsigned clock_hz,
                                              input int unsigned baud);
    return bit_cycles(clock_hz, baud) / 2;
  endfunction

endpackage

// File: rtl/midi_sync.sv
// Generic two-flop synchronizer for a single asynchronous input, with a
// selectable reset value so idle-high lines come out of reset as idle.
module midi_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so both stages
  // update from their pre-edge values and the pipeline really is two deep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/midi_uart_rx.sv
// MIDI 8N1 receiver: synchronizes the raw input line, samples each bit at
// mid-period and emits one-cycle data_valid / framing_err strobes.
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int unsigned CLOCK = 12_000_000,
  parameter int unsigned BAUD  = MIDI_BAUD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       framing_err,
  output logic       busy
);

  localparam int unsigned BIT  = bit_cycles(CLOCK, BAUD);
  localparam int unsigned HALF = half_cycles(CLOCK, BAUD);
  localparam int unsigned CW   = $clog2(BIT);

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT - 1);

  generate
    if (BIT < 4) begin : g_bit_too_short
      $error("midi_uart_rx: CLOCK/BAUD must be at least 4");
    end
  endgenerate

  logic            rxs;
  rx_state_e       state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;

  midi_sync #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rxs)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      data        <= 8'h00;
      data_valid  <= 1'b0;
      framing_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      // NOTE: strobes default low every cycle so each pulse lasts exactly one
      // cycle and no path leaves them holding a stale value.
      data_valid  <= 1'b0;
      framing_err <= 1'b0;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rxs) begin
            state <= START;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (rxs) begin
              // Line went back high before mid-start: a glitch, not a frame.
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shreg   <= {rxs, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rxs) begin
              data       <= shreg;
              data_valid <= 1'b1;
              state      <= IDLE;
              busy       <= 1'b0;
            end else begin
              framing_err <= 1'b1;
              state       <= BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        BREAK: begin
          // A held-low line reports once, then waits silently for idle.
          if (rxs) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          cnt   <= '0;
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_midi_uart_rx.sv
// Bench for midi_uart_rx: directed frames queue their expected strobes in a
// scoreboard; a negedge monitor pops and compares whenever a strobe appears.
`timescale 1ns/1ps
module tb_midi_uart_rx;

  localparam int unsigned BIT     = 384;
  localparam int unsigned HALF    = 192;
  localparam int unsigned LATENCY = 3651;  // start-drive cycle to strobe sample

  typedef struct {
    bit          is_err;
    logic [7:0]  data;
    int unsigned cyc;
    bit          timed;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       data_valid;
  logic       framing_err;
  logic       busy;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  last_data = 8'h00;
  exp_t        sb[$];

  midi_uart_rx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .data        (data),
    .data_valid  (data_valid),
    .framing_err (framing_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one 8N1 frame with the given bit length and stop-bit level.
  task automatic send_frame(input logic [7:0] b, input int unsigned bit_len,
                            input logic stop_val, input bit timed);
    exp_t e;
    e.is_err = !stop_val;
    e.data   = stop_val ? b : last_data;
    e.cyc    = cyc + LATENCY;
    e.timed  = timed;
    sb.push_back(e);
    if (stop_val) last_data = b;
    rx = 1'b0;
    repeat (bit_len) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (bit_len) tick();
    end
    rx = stop_val;
    repeat (bit_len) tick();
  endtask

  // Scoreboard monitor, sampling away from the active edge.
  always @(negedge clk) begin
    if (rst_n && (data_valid || framing_err)) begin
      check("strobe_exclusive", {31'd0, data_valid & framing_err}, 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got dv=%0b fe=%0b data=0x%0h, expected none (cycle %0d)",
                 data_valid, framing_err, data, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("strobe_kind", {31'd0, framing_err}, {31'd0, e.is_err});
        check("strobe_data", {24'd0, data}, {24'd0, e.data});
        if (e.timed) check("strobe_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    int hi;

    // Reset state
    repeat (3) tick();
    check("reset_data", {24'd0, data}, 32'd0);
    check("reset_dv", {31'd0, data_valid}, 32'd0);
    check("reset_fe", {31'd0, framing_err}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    repeat (10) tick();

    // Single byte with exact latency
    send_frame(8'h90, BIT, 1'b1, 1'b1);
    repeat (50) tick();

    // Glitch: 100 low cycles then high; busy for HALF cycles only
    hi = 0;
    rx = 1'b0;
    for (int i = 1; i <= 400; i++) begin
      tick();
      if (i == 100) rx = 1'b1;
      if (i == 2) check("glitch_busy_pre", {31'd0, busy}, 32'd0);
      if (i == 3) check("glitch_busy_rise", {31'd0, busy}, 32'd1);
      if (i >= 3 && busy) hi++;
    end
    check("glitch_busy_len", hi, HALF);
    check("glitch_idle", {31'd0, busy}, 32'd0);

    // Stop bit low, break of 2000 cycles, then a good byte
    send_frame(8'h55, BIT, 1'b0, 1'b1);
    repeat (2000) tick();
    check("break_busy", {31'd0, busy}, 32'd1);
    check("break_data_hold", {24'd0, data}, 32'h90);
    rx = 1'b1;
    repeat (50) tick();
    check("break_released", {31'd0, busy}, 32'd0);
    send_frame(8'h3C, BIT, 1'b1, 1'b1);
    repeat (50) tick();

    // Back-to-back frames, no idle gap
    send_frame(8'h90, BIT, 1'b1, 1'b1);
    send_frame(8'h3C, BIT, 1'b1, 1'b1);
    send_frame(8'h7F, BIT, 1'b1, 1'b1);
    repeat (50) tick();

    // Bit rate skewed by -2 % and +2 %
    send_frame(8'hA5, 376, 1'b1, 1'b0);
    repeat (50) tick();
    send_frame(8'hA5, 392, 1'b1, 1'b0);
    repeat (50) tick();

    // Reset during bit 4 of 8'hFF
    rx = 1'b0;
    repeat (BIT) tick();
    rx = 1'b1;
    repeat (4 * BIT + 100) tick();
    rst_n = 1'b0;
    #1;
    check("midreset_data", {24'd0, data}, 32'd0);
    check("midreset_dv", {31'd0, data_valid}, 32'd0);
    check("midreset_fe", {31'd0, framing_err}, 32'd0);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    last_data = 8'h00;
    repeat (5) tick();
    rst_n = 1'b1;
    repeat (4 * BIT) tick();
    check("postreset_busy", {31'd0, busy}, 32'd0);
    send_frame(8'h12, BIT, 1'b1, 1'b1);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 5000 && sb.size() != 0; i++) tick();
    check("scoreboard_drained", sb.size(), 32'd0);
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
